seg_display_scheduler: RTL and testbench
========================================

// Module: seg_display_scheduler
// PURPOSE
//   Shares the 4-digit seven-segment display between NUM_SRC requesters (score, timer, song no.).
//   Round-robins the active requesters every DWELL_CYCLES; src 0 (alert) preempts.
//   Converts the winning binary value to 4-digit BCD with a multi-cycle double-dabble.
//   Drives the digit/blank inputs of the display driver.
// PARAMETERS
//   NUM_SRC       3            number of requesters (2..8)
//   DWELL_CYCLES  200_000_000  hold time per source (2 s @ 100 MHz)
//   VALUE_W       14           binary value width per source
// PORTS
//   clock_100Mhz  in   1               system clock
//   reset_n       in   1               asynchronous, active-low reset
//   src_req       in   NUM_SRC         level request per source
//   src_value     in   NUM_SRC*VALUE_W values; src i at [i*VALUE_W +: VALUE_W]
//   src_grant     out  NUM_SRC         one-hot: source currently shown (0 = none)
//   disp_bcd      out  16              BCD digits; [15:12] leftmost ... [3:0] rightmost
//   disp_blank    out  4               1 = digit dark; bit3 leftmost
//   disp_update   out  1               1-cycle pulse when disp_bcd/src_grant change
//   busy          out  1               high in SELECT/CONVERT
// BEHAVIOUR
//   Reset values: src_grant=0, disp_bcd=16'h0000, disp_blank=4'b1111, disp_update=0, busy=0;
//     FSM=IDLE, rr pointer=NUM_SRC-1 (src 0 wins first), dwell counter=0. Reset acts mid-conversion too.
//   FSM: IDLE -> SELECT -> CONVERT -> HOLD -> (SELECT | IDLE).
//   IDLE: leave on any src_req bit high.
//   SELECT (1 cycle): pick the first requester after the rr pointer (circular); snapshot its value.
//     Values >9999 saturate to 9999. Pointer := winner.
//   CONVERT: exactly 14 cycles of shift-add-3; src_value changes here are ignored.
//   Commit on HOLD entry: disp_bcd, src_grant, disp_blank update together; disp_update=1 for 1 cycle.
//     Latency: the req sampled in IDLE at edge 0 produces the commit at edge 16.
//   HOLD: dwell counter counts 0..DWELL_CYCLES-1. At expiry:
//     - other requesters active -> SELECT (next round-robin);
//     - only the granted source active -> SELECT of the same source (value refresh; dwell restarts).
//   Granted source drops src_req in HOLD -> SELECT next cycle if any other req, else IDLE.
//     On IDLE entry: src_grant=0, disp_blank=4'b1111, disp_bcd retained, no disp_update.
//   Preempt: rising src_req[0] in HOLD while another source is granted -> SELECT src 0.
//     Pointer is forced to src 0.
//   Simultaneous events: preempt > grant drop > dwell expiry.
//     Req changes during SELECT/CONVERT are only evaluated in HOLD.
//   Dwell counter width = $clog2(DWELL_CYCLES); no wrap beyond DWELL_CYCLES-1.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: leading zero digits are blanked while granted.
//     The rightmost digit is never blanked. Examples: 0 -> 4'b1110, 42 -> 4'b1100, 1234 -> 4'b0000.
//   Not defined: disp_blank=4'b0000 whenever a source is granted; 4'b1111 otherwise.
// STRUCTURE
//   Package seg_disp_pkg:
//     state_t enum {IDLE, SELECT, CONVERT, HOLD}.
//     Constants BCD_W=16, MAX_VALUE=9999, BLANK_ALL=4'b1111, CONV_CYCLES=14.
//   Sub-module bin2bcd_seq: start/done iterative double-dabble.
//     VALUE_W in, 16-bit BCD out, done 14 cycles after start.
//   Top holds the FSM, rr arbiter, dwell counter, and output registers.
// TESTING (bench: DWELL_CYCLES=20)
//   1. Reset low mid-CONVERT -> all outputs at reset values the same cycle; IDLE on release.
//   2. src_req=3'b010, value1=1234 -> disp_update 16 cycles later;
//      disp_bcd=16'h1234, src_grant=3'b010.
//   3. src_req=3'b110, value1=7, value2=500 -> alternates src1/src2 every 20+16 cycles;
//      check 16'h0007 / 16'h0500.
//   4. src1 in HOLD, raise src_req[0] (value0=9) -> next cycle SELECT;
//      16 cycles later src_grant=3'b001, disp_bcd=16'h0009.
//   5. value2=12000 -> disp_bcd=16'h9999 (saturation).
//      Drop src_req[2] in HOLD with no others -> src_grant=0, disp_blank=4'b1111.
//   6. LEADING_ZERO_BLANK_EN: value=42 -> disp_blank=4'b1100; value=0 -> 4'b1110.
//      Without the macro -> 4'b0000.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared types, constants and BCD helpers for the seven-segment display scheduler.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    CONVERT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int         BCD_W       = 16;
  localparam int         MAX_VALUE   = 9999;
  localparam logic [3:0] BLANK_ALL   = 4'b1111;
  localparam int         CONV_CYCLES = 14;

  // Double-dabble adjust step: every digit >= 5 gets +3 before the shift.
  function automatic logic [15:0] bcd_add3(input logic [15:0] bcd);
    logic [15:0] res;
    res = 16'h0000;
    for (int d = 0; d < 4; d++) begin
      res[d*4 +: 4] = (bcd[d*4 +: 4] >= 4'd5) ? (bcd[d*4 +: 4] + 4'd3) : bcd[d*4 +: 4];
    end
    return res;
  endfunction

  function automatic logic [3:0] lz_blank(input logic [15:0] bcd);
    logic [3:0] blank;
    blank[3] = (bcd[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd[7:4] == 4'd0);
    blank[0] = 1'b0;
    return blank;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift-add-3 step per cycle, done pulses
// CONV_CYCLES cycles after start. Input must already be saturated to MAX_VALUE.
module bin2bcd_seq
  import seg_disp_pkg::*;
#(
  parameter int VALUE_W = 14
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [VALUE_W-1:0] value_i,
  output logic               done_o,
  output logic [BCD_W-1:0]   bcd_o
);

  localparam int CW = $clog2(CONV_CYCLES);

  logic [CONV_CYCLES-1:0] bin_q;
  logic [BCD_W-1:0]       bcd_q;
  logic [BCD_W-1:0]       adj_s;
  logic [CW-1:0]          cnt_q;
  logic                   run_q;
  logic                   done_q;

  assign adj_s = bcd_add3(bcd_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      bin_q  <= value_i[CONV_CYCLES-1:0];
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      bcd_q <= {adj_s[BCD_W-2:0], bin_q[CONV_CYCLES-1]};
      bin_q <= {bin_q[CONV_CYCLES-2:0], 1'b0};
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(CONV_CYCLES - 1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin scheduler sharing a 4-digit seven-segment display among NUM_SRC requesters,
// src 0 preempts. Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_display_scheduler
  import seg_disp_pkg::*;
#(
  parameter int NUM_SRC      = 3,
  parameter int DWELL_CYCLES = 200_000_000,
  parameter int VALUE_W      = 14
) (
  input  logic                       clock_100Mhz,
  input  logic                       reset_n,
  input  logic [NUM_SRC-1:0]         src_req,
  input  logic [NUM_SRC*VALUE_W-1:0] src_value,
  output logic [NUM_SRC-1:0]         src_grant,
  output logic [BCD_W-1:0]           disp_bcd,
  output logic [3:0]                 disp_blank,
  output logic                       disp_update,
  output logic                       busy
);

  localparam int             PW         = $clog2(NUM_SRC);
  localparam int             DW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL_CYCLES - 1);

  state_t               state_q;
  logic [PW-1:0]        rr_ptr_q;
  logic [DW-1:0]        dwell_q;
  logic [DW-1:0]        dwell_d;
  logic [NUM_SRC-1:0]   grant_q;
  logic [NUM_SRC-1:0]   sel_oh_q;
  logic [BCD_W-1:0]     bcd_q;
  logic [3:0]           blank_q;
  logic                 update_q;
  logic                 busy_q;
  logic                 req0_prev_q;

  logic                 win_valid_s;
  logic [PW-1:0]        win_idx_s;
  logic [NUM_SRC-1:0]   win_oh_s;
  logic [VALUE_W-1:0]   win_val_s;
  logic [VALUE_W-1:0]   sat_val_s;
  logic                 conv_start_s;
  logic                 conv_done_s;
  logic [BCD_W-1:0]     conv_bcd_s;
  logic [3:0]           commit_blank_s;
  logic                 preempt_s;
  logic                 drop_s;
  logic                 others_s;

  // Circular search starting after the pointer: the second loop (sources above the
  // pointer) overrides the first, and descending order leaves the lowest index.
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = '0;
    win_val_s   = '0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      win_idx_s   = (src_req[j] && (j <= int'(rr_ptr_q))) ? PW'(j) : win_idx_s;
      win_valid_s = win_valid_s | (src_req[j] && (j <= int'(rr_ptr_q)));
    end
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      win_idx_s   = (src_req[j] && (j > int'(rr_ptr_q))) ? PW'(j) : win_idx_s;
      win_valid_s = win_valid_s | (src_req[j] && (j > int'(rr_ptr_q)));
    end
    for (int j = 0; j < NUM_SRC; j++) begin
      win_val_s = (PW'(j) == win_idx_s) ? src_value[j*VALUE_W +: VALUE_W] : win_val_s;
    end
    win_oh_s = win_valid_s ? (NUM_SRC'(1) << win_idx_s) : '0;
  end

  assign sat_val_s    = (win_val_s > VALUE_W'(MAX_VALUE)) ? VALUE_W'(MAX_VALUE) : win_val_s;
  assign conv_start_s = (state_q == SELECT) && win_valid_s;
  assign dwell_d      = (dwell_q == DWELL_LAST) ? dwell_q : (dwell_q + DW'(1));

  // Source 0 only preempts on a fresh rise, not on a level it already held.
  assign preempt_s = src_req[0] && !req0_prev_q && !grant_q[0];
  assign drop_s    = ~|(src_req & grant_q);
  assign others_s  = |(src_req & ~grant_q);

`ifdef LEADING_ZERO_BLANK_EN
  assign commit_blank_s = lz_blank(conv_bcd_s);
`else
  assign commit_blank_s = 4'b0000;
`endif

  bin2bcd_seq #(
    .VALUE_W (VALUE_W)
  ) u_bin2bcd (
    .clk_i   (clock_100Mhz),
    .rst_ni  (reset_n),
    .start_i (conv_start_s),
    .value_i (sat_val_s),
    .done_o  (conv_done_s),
    .bcd_o   (conv_bcd_s)
  );

  // Scheduler FSM with registered display outputs.
  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= PW'(NUM_SRC - 1);
      dwell_q     <= '0;
      grant_q     <= '0;
      sel_oh_q    <= '0;
      bcd_q       <= '0;
      blank_q     <= BLANK_ALL;
      update_q    <= 1'b0;
      busy_q      <= 1'b0;
      req0_prev_q <= 1'b0;
    end else begin
      update_q <= 1'b0;
      if ((state_q == IDLE) || (state_q == HOLD)) begin
        req0_prev_q <= src_req[0];
      end
      case (state_q)
        IDLE: begin
          if (|src_req) begin
            state_q <= SELECT;
            busy_q  <= 1'b1;
          end
        end
        SELECT: begin
          if (win_valid_s) begin
            rr_ptr_q <= win_idx_s;
            sel_oh_q <= win_oh_s;
            state_q  <= CONVERT;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            grant_q <= '0;
            blank_q <= BLANK_ALL;
          end
        end
        CONVERT: begin
          if (conv_done_s) begin
            state_q  <= HOLD;
            busy_q   <= 1'b0;
            grant_q  <= sel_oh_q;
            bcd_q    <= conv_bcd_s;
            blank_q  <= commit_blank_s;
            update_q <= 1'b1;
            dwell_q  <= '0;
          end
        end
        HOLD: begin
          if (preempt_s) begin
            rr_ptr_q <= PW'(NUM_SRC - 1);
            state_q  <= SELECT;
            busy_q   <= 1'b1;
          end else if (drop_s) begin
            if (others_s) begin
              state_q <= SELECT;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
              blank_q <= BLANK_ALL;
            end
          end else if (dwell_q == DWELL_LAST) begin
            state_q <= SELECT;
            busy_q  <= 1'b1;
          end else begin
            dwell_q <= dwell_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign src_grant   = grant_q;
  assign disp_bcd    = bcd_q;
  assign disp_blank  = blank_q;
  assign disp_update = update_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with a short dwell (20 cycles).
module tb_seg_display_scheduler;

  localparam int NS = 3;
  localparam int VW = 14;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] BL_1234 = 4'b0000;
  localparam logic [3:0] BL_500  = 4'b1000;
  localparam logic [3:0] BL_7    = 4'b1110;
  localparam logic [3:0] BL_9    = 4'b1110;
  localparam logic [3:0] BL_9999 = 4'b0000;
  localparam logic [3:0] BL_42   = 4'b1100;
  localparam logic [3:0] BL_0    = 4'b1110;
  localparam logic [3:0] BL_77   = 4'b1100;
`else
  localparam logic [3:0] BL_1234 = 4'b0000;
  localparam logic [3:0] BL_500  = 4'b0000;
  localparam logic [3:0] BL_7    = 4'b0000;
  localparam logic [3:0] BL_9    = 4'b0000;
  localparam logic [3:0] BL_9999 = 4'b0000;
  localparam logic [3:0] BL_42   = 4'b0000;
  localparam logic [3:0] BL_0    = 4'b0000;
  localparam logic [3:0] BL_77   = 4'b0000;
`endif

  logic             clock_100Mhz;
  logic             reset_n;
  logic [NS-1:0]    src_req;
  logic [NS*VW-1:0] src_value;
  logic [NS-1:0]    src_grant;
  logic [15:0]      disp_bcd;
  logic [3:0]       disp_blank;
  logic             disp_update;
  logic             busy;

  int total = 0;
  int bad   = 0;

  seg_display_scheduler #(
    .NUM_SRC      (NS),
    .DWELL_CYCLES (20),
    .VALUE_W      (VW)
  ) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset_n      (reset_n),
    .src_req      (src_req),
    .src_value    (src_value),
    .src_grant    (src_grant),
    .disp_bcd     (disp_bcd),
    .disp_blank   (disp_blank),
    .disp_update  (disp_update),
    .busy         (busy)
  );

  initial clock_100Mhz = 1'b0;
  always #5 clock_100Mhz = ~clock_100Mhz;

  task automatic wait_update(input int max_cyc, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && (n < max_cyc)) begin
      @(negedge clock_100Mhz);
      n++;
      if (disp_update) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    src_req = '0;
    src_value = '0;
    repeat (2) @(negedge clock_100Mhz);
    total++; if (src_grant !== 3'b000) begin bad++; $display("FAIL reset_grant: got %b want 000", src_grant); end
    total++; if (disp_bcd !== 16'h0000) begin bad++; $display("FAIL reset_bcd: got %h want 0000", disp_bcd); end
    total++; if (disp_blank !== 4'b1111) begin bad++; $display("FAIL reset_blank: got %b want 1111", disp_blank); end
    total++; if ({disp_update, busy} !== 2'b00) begin bad++; $display("FAIL reset_upd_busy: got %b want 00", {disp_update, busy}); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock_100Mhz);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int n; bit seen;
    src_value[1*VW +: VW] = 14'd1234;
    src_req = 3'b010;
    wait_update(40, n, seen);
    total++; if (!seen || n != 17) begin bad++; $display("FAIL single_latency: got %0d (seen=%0d) want 17", n, seen); end
    total++; if (disp_bcd !== 16'h1234) begin bad++; $display("FAIL single_bcd: got %h want 1234", disp_bcd); end
    total++; if (src_grant !== 3'b010) begin bad++; $display("FAIL single_grant: got %b want 010", src_grant); end
    total++; if (disp_blank !== BL_1234) begin bad++; $display("FAIL single_blank: got %b want %b", disp_blank, BL_1234); end
    @(negedge clock_100Mhz);
    total++; if (disp_update !== 1'b0) begin bad++; $display("FAIL single_pulse: got %b want 0", disp_update); end
  endtask

  task automatic test_round_robin();
    int n; bit seen;
    src_value[1*VW +: VW] = 14'd7;
    src_value[2*VW +: VW] = 14'd500;
    src_req = 3'b110;
    wait_update(100, n, seen);
    total++; if (!seen || n != 35) begin bad++; $display("FAIL rr_first_wait: got %0d (seen=%0d) want 35", n, seen); end
    total++; if (disp_bcd !== 16'h0500 || src_grant !== 3'b100) begin bad++; $display("FAIL rr_src2: got %h/%b want 0500/100", disp_bcd, src_grant); end
    total++; if (disp_blank !== BL_500) begin bad++; $display("FAIL rr_blank500: got %b want %b", disp_blank, BL_500); end
    wait_update(100, n, seen);
    total++; if (!seen || n != 36) begin bad++; $display("FAIL rr_period: got %0d (seen=%0d) want 36", n, seen); end
    total++; if (disp_bcd !== 16'h0007 || src_grant !== 3'b010) begin bad++; $display("FAIL rr_src1: got %h/%b want 0007/010", disp_bcd, src_grant); end
    total++; if (disp_blank !== BL_7) begin bad++; $display("FAIL rr_blank7: got %b want %b", disp_blank, BL_7); end
  endtask

  task automatic test_preempt();
    int n; bit seen;
    src_value[0 +: VW] = 14'd9;
    src_req = 3'b011;
    @(negedge clock_100Mhz);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL preempt_select: busy got %b want 1", busy); end
    wait_update(40, n, seen);
    total++; if (!seen || n != 16) begin bad++; $display("FAIL preempt_latency: got %0d (seen=%0d) want 16", n, seen); end
    total++; if (src_grant !== 3'b001 || disp_bcd !== 16'h0009) begin bad++; $display("FAIL preempt_src0: got %b/%h want 001/0009", src_grant, disp_bcd); end
    total++; if (disp_blank !== BL_9) begin bad++; $display("FAIL preempt_blank: got %b want %b", disp_blank, BL_9); end
  endtask

  task automatic test_saturate_drop();
    int n; bit seen;
    src_value[2*VW +: VW] = 14'd12000;
    src_req = 3'b100;
    wait_update(40, n, seen);
    total++; if (!seen || n != 17) begin bad++; $display("FAIL drop_switch_latency: got %0d (seen=%0d) want 17", n, seen); end
    total++; if (disp_bcd !== 16'h9999 || src_grant !== 3'b100) begin bad++; $display("FAIL saturate: got %h/%b want 9999/100", disp_bcd, src_grant); end
    total++; if (disp_blank !== BL_9999) begin bad++; $display("FAIL saturate_blank: got %b want %b", disp_blank, BL_9999); end
    src_req = 3'b000;
    @(negedge clock_100Mhz);
    total++; if (src_grant !== 3'b000 || disp_blank !== 4'b1111) begin bad++; $display("FAIL drop_idle: got %b/%b want 000/1111", src_grant, disp_blank); end
    total++; if (disp_bcd !== 16'h9999 || disp_update !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL drop_retain: got %h upd=%b busy=%b want 9999 0 0", disp_bcd, disp_update, busy); end
  endtask

  task automatic test_blank_refresh();
    int n; bit seen;
    src_value[1*VW +: VW] = 14'd42;
    src_req = 3'b010;
    wait_update(40, n, seen);
    total++; if (!seen || disp_bcd !== 16'h0042) begin bad++; $display("FAIL blank42_bcd: got %h (seen=%0d) want 0042", disp_bcd, seen); end
    total++; if (disp_blank !== BL_42) begin bad++; $display("FAIL blank42: got %b want %b", disp_blank, BL_42); end
    src_value[1*VW +: VW] = 14'd0;
    repeat (19) @(negedge clock_100Mhz);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dwell_early: busy got %b want 0", busy); end
    @(negedge clock_100Mhz);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL dwell_expiry: busy got %b want 1", busy); end
    @(negedge clock_100Mhz);
    src_value[1*VW +: VW] = 14'd77;
    wait_update(40, n, seen);
    total++; if (!seen || n != 15) begin bad++; $display("FAIL refresh_latency: got %0d (seen=%0d) want 15", n, seen); end
    total++; if (disp_bcd !== 16'h0000 || src_grant !== 3'b010) begin bad++; $display("FAIL refresh_zero: got %h/%b want 0000/010", disp_bcd, src_grant); end
    total++; if (disp_blank !== BL_0) begin bad++; $display("FAIL blank0: got %b want %b", disp_blank, BL_0); end
    wait_update(60, n, seen);
    total++; if (!seen || n != 36 || disp_bcd !== 16'h0077) begin bad++; $display("FAIL refresh77: got %h n=%0d (seen=%0d) want 0077 36", disp_bcd, n, seen); end
    total++; if (disp_blank !== BL_77) begin bad++; $display("FAIL blank77: got %b want %b", disp_blank, BL_77); end
  endtask

  task automatic test_reset_mid_convert();
    int n; bit seen;
    repeat (22) @(negedge clock_100Mhz);
    total++; if (busy !== 1'b1 || src_grant !== 3'b010) begin bad++; $display("FAIL midconv_pre: busy=%b grant=%b want 1/010", busy, src_grant); end
    reset_n = 1'b0;
    #1;
    total++; if (src_grant !== 3'b000 || disp_bcd !== 16'h0000) begin bad++; $display("FAIL midconv_reset: got %b/%h want 000/0000", src_grant, disp_bcd); end
    total++; if (disp_blank !== 4'b1111 || disp_update !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midconv_reset2: blank=%b upd=%b busy=%b want 1111 0 0", disp_blank, disp_update, busy); end
    src_req = 3'b000;
    @(negedge clock_100Mhz);
    reset_n = 1'b1;
    repeat (3) @(negedge clock_100Mhz);
    total++; if (busy !== 1'b0 || src_grant !== 3'b000 || disp_update !== 1'b0) begin bad++; $display("FAIL post_reset_idle: busy=%b grant=%b upd=%b want 0 000 0", busy, src_grant, disp_update); end
    src_value[1*VW +: VW] = 14'd1234;
    src_req = 3'b010;
    wait_update(40, n, seen);
    total++; if (!seen || n != 17 || disp_bcd !== 16'h1234) begin bad++; $display("FAIL post_reset_conv: got %h n=%0d (seen=%0d) want 1234 17", disp_bcd, n, seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_saturate_drop();
    test_blank_refresh();
    test_reset_mid_convert();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
